// File: rtl/qdec_pkg.sv
// qdec_pkg: shared state type, AB phase encodings, defaults and step helpers for the quadrature decoder
package qdec_pkg;
    typedef enum logic {INIT, RUN} qdec_state_t;
    localparam logic [1:0] AB_00 = 2'b00;
    localparam logic [1:0] AB_10 = 2'b10;
    localparam logic [1:0] AB_11 = 2'b11;
    localparam logic [1:0] AB_01 = 2'b01;
    localparam int DEF_FILT_LEN = 4;
    localparam int DEF_POS_W = 32;
    // {A,B} one forward quarter-cycle after ab (A leads B)
    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        return ab == AB_00 ? AB_10 : ab == AB_10 ? AB_11 : ab == AB_11 ? AB_01 : AB_00;
    endfunction
    // {A,B} one reverse quarter-cycle after ab
    function automatic logic [1:0] rev_next(input logic [1:0] ab);
        return ab == AB_00 ? AB_01 : ab == AB_01 ? AB_11 : ab == AB_11 ? AB_10 : AB_00;
    endfunction
endpackage

// File: rtl/quad_filter.sv
// quad_filter: 2-FF synchronizer plus FILT_LEN-sample persistence filter with stable flag
//   freq_clk, rst_n : clock, async active-low reset
//   raw             : asynchronous input
//   filt            : filtered level, follows raw after FILT_LEN agreeing synchronized samples
//   stable          : synchronized input has matched filt for FILT_LEN samples
module quad_filter import qdec_pkg::*; #(
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic freq_clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt,
    output logic stable
);
    localparam logic [3:0] CNT_LEN = 4'(FILT_LEN);
    localparam logic [3:0] CNT_MAX = 4'(FILT_LEN - 1);
    logic [1:0] sync;
    logic [1:0] primed;
    logic [3:0] diff_cnt;
    logic [3:0] same_cnt;
    // primed keeps the reset contents of the synchronizer from counting toward stable
    always_ff @(posedge freq_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            primed <= '0;
            diff_cnt <= '0;
            same_cnt <= '0;
            filt <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            primed <= {primed[0], 1'b1};
            if (sync[1] != filt) begin
                same_cnt <= '0;
                diff_cnt <= diff_cnt == CNT_MAX ? '0 : diff_cnt + 4'd1;
                filt <= diff_cnt == CNT_MAX ? sync[1] : filt;
            end else begin
                diff_cnt <= '0;
                same_cnt <= primed[1] && !stable ? same_cnt + 4'd1 : same_cnt;
            end
        end
    end
    assign stable = same_cnt == CNT_LEN;
endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: filtered quadrature decoder with position counter, index latch, home flag and error flag
//   freq_clk, rst_n        : clock, async active-low reset
//   pha, phb, index, home  : raw asynchronous encoder inputs
//   clr, idx_clr_en, err_clr : sync clear, index-zeroes-position enable, error clear
//   position, dir, step    : signed count, last direction (1 = forward), per-step pulse
//   idx_pos, idx_valid     : position captured at index rising edge, sticky capture flag
//   home_seen, err         : sticky home-edge flag, sticky illegal-transition flag
module quad_decoder import qdec_pkg::*; #(
    parameter int FILT_LEN = DEF_FILT_LEN,
    parameter int POS_W = DEF_POS_W
) (
    input  logic             freq_clk,
    input  logic             rst_n,
    input  logic             pha,
    input  logic             phb,
    input  logic             index,
    input  logic             home,
    input  logic             clr,
    input  logic             idx_clr_en,
    input  logic             err_clr,
    output logic [POS_W-1:0] position,
    output logic             dir,
    output logic             step,
    output logic [POS_W-1:0] idx_pos,
    output logic             idx_valid,
    output logic             home_seen,
    output logic             err
);
    logic [3:0] raw, filt, stable;
    logic [1:0] ab, prev_ab;
    logic idx_q, home_q, run, fwd, rev, ill, idx_rise, home_rise;
    logic [POS_W-1:0] pos_step;
    qdec_state_t state_q, state_d;
    assign raw = {pha, phb, index, home};
    assign ab = filt[3:2];
    for (genvar i = 0; i < 4; i++) begin : g_filt
        quad_filter #(.FILT_LEN(FILT_LEN)) u_filt (
            .freq_clk(freq_clk),
            .rst_n(rst_n),
            .raw(raw[i]),
            .filt(filt[i]),
            .stable(stable[i])
        );
    end
    // INIT ignores all edges; decoding only starts once every filter has settled
    always_comb begin
        state_d = state_q == INIT && &stable ? RUN : state_q;
        run = state_q == RUN;
        fwd = run && ab == fwd_next(prev_ab);
        rev = run && ab == rev_next(prev_ab);
        ill = run && ab == ~prev_ab;
        idx_rise = run && filt[1] && !idx_q;
        home_rise = run && filt[0] && !home_q;
        pos_step = fwd ? position + POS_W'(1) : rev ? position - POS_W'(1) : position;
    end
    always_ff @(posedge freq_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            prev_ab <= AB_00;
            idx_q <= 1'b0;
            home_q <= 1'b0;
            position <= '0;
            dir <= 1'b0;
            step <= 1'b0;
            idx_pos <= '0;
            idx_valid <= 1'b0;
            home_seen <= 1'b0;
            err <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_ab <= run || &stable ? ab : prev_ab;
            idx_q <= filt[1];
            home_q <= filt[0];
            step <= fwd || rev;
            dir <= fwd || rev ? fwd : dir;
            position <= clr || (idx_rise && idx_clr_en) ? '0 : pos_step;
            idx_pos <= clr ? '0 : idx_rise ? pos_step : idx_pos;
            idx_valid <= !clr && (idx_rise || idx_valid);
            home_seen <= !clr && (home_rise || home_seen);
            err <= ill || (err && !err_clr);
        end
    end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: table-driven and scoreboard checks of quad_decoder with FILT_LEN=4, POS_W=32
module tb_quad_decoder;
    logic freq_clk = 1'b0;
    logic rst_n = 1'b0;
    logic pha = 1'b0, phb = 1'b0, index = 1'b0, home = 1'b0;
    logic clr = 1'b0, idx_clr_en = 1'b0, err_clr = 1'b0;
    logic [31:0] position, idx_pos;
    logic dir, step, idx_valid, home_seen, err;

    always #5 freq_clk = ~freq_clk;

    quad_decoder #(.FILT_LEN(4), .POS_W(32)) dut (
        .freq_clk(freq_clk), .rst_n(rst_n), .pha(pha), .phb(phb), .index(index), .home(home),
        .clr(clr), .idx_clr_en(idx_clr_en), .err_clr(err_clr), .position(position), .dir(dir),
        .step(step), .idx_pos(idx_pos), .idx_valid(idx_valid), .home_seen(home_seen), .err(err)
    );

    int vec_cnt = 0, miss_cnt = 0, step_cnt = 0, err_hi = 0;
    always @(negedge freq_clk) begin
        if (step) step_cnt++;
        if (err) err_hi++;
    end

    typedef struct {string nm; logic [31:0] pos; logic dir; logic err; int steps;} exp_t;
    typedef struct {logic a; logic b; logic [31:0] pos; logic dir;} vec_t;
    exp_t sb[$];
    vec_t tbl[18];
    logic [1:0] seq[18] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00,
                            2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00};
    int exp_steps = 0;
    logic [31:0] exp_pos = '0;
    logic [1:0] cur_ab = 2'b00;

    task automatic cyc(input int n);
        repeat (n) @(negedge freq_clk);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vec_cnt++;
        if (act !== req) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic push(input string nm, input logic [31:0] p, input logic d, input logic e);
        sb.push_back('{nm: nm, pos: p, dir: d, err: e, steps: exp_steps});
    endtask

    task automatic pop_chk();
        exp_t x;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        x = sb.pop_front();
        chk({x.nm, "_pos"}, position, x.pos);
        chk({x.nm, "_dir"}, dir, x.dir);
        chk({x.nm, "_err"}, err, x.err);
        chk({x.nm, "_steps"}, step_cnt, x.steps);
    endtask

    function automatic logic [1:0] nxt(input logic [1:0] ab);
        case (ab)
            2'b00: return 2'b10;
            2'b10: return 2'b11;
            2'b11: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic fwd_steps(input int n);
        for (int k = 0; k < n; k++) begin
            cur_ab = nxt(cur_ab);
            {pha, phb} = cur_ab;
            exp_pos = exp_pos + 32'd1;
            exp_steps++;
            push("fwd", exp_pos, 1'b1, 1'b0);
            cyc(12);
            pop_chk();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, s0, e0;
        for (int i = 0; i < 18; i++) begin
            tbl[i].a = seq[i][1];
            tbl[i].b = seq[i][0];
            tbl[i].pos = i < 8 ? 32'(i + 1) : i < 17 ? 32'(15 - i) : 32'd0;
            tbl[i].dir = i < 8 || i == 17;
        end
        cyc(3);
        chk("rst_position", position, 0);
        chk("rst_dir", dir, 0);
        chk("rst_step", step, 0);
        chk("rst_idx_pos", idx_pos, 0);
        chk("rst_idx_valid", idx_valid, 0);
        chk("rst_home_seen", home_seen, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        cyc(20);
        for (int i = 0; i < 18; i++) begin
            {pha, phb} = {tbl[i].a, tbl[i].b};
            exp_steps++;
            push($sformatf("vec%0d", i), tbl[i].pos, tbl[i].dir, 1'b0);
            cyc(20);
            pop_chk();
        end
        pha = 1'b1;
        lat = 0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            cyc(1);
            if (step) lat = n;
        end
        chk("step_latency", lat, 7);
        exp_steps++;
        push("lat_fwd", 32'd1, 1'b1, 1'b0);
        cyc(20);
        pop_chk();
        pha = 1'b0;
        exp_steps++;
        push("lat_rev", 32'd0, 1'b0, 1'b0);
        cyc(20);
        pop_chk();
        pha = 1'b1;
        cyc(3);
        pha = 1'b0;
        push("glitch3", 32'd0, 1'b0, 1'b0);
        cyc(20);
        pop_chk();
        pha = 1'b1;
        cyc(4);
        pha = 1'b0;
        exp_steps += 2;
        push("pulse4", 32'd0, 1'b0, 1'b0);
        cyc(20);
        pop_chk();
        {pha, phb} = 2'b11;
        cur_ab = 2'b11;
        push("illegal", 32'd0, 1'b0, 1'b1);
        cyc(20);
        pop_chk();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(2);
        chk("err_clr", err, 0);
        exp_pos = 32'd0;
        fwd_steps(2);
        err_clr = 1'b1;
        e0 = err_hi;
        {pha, phb} = 2'b11;
        cur_ab = 2'b11;
        cyc(20);
        err_clr = 1'b0;
        chk("err_set_wins_cycles", err_hi - e0, 1);
        chk("err_after_hold", err, 0);
        chk("illegal2_pos", position, 2);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(2);
        chk("clr_pos", position, 0);
        exp_pos = 32'd0;
        fwd_steps(25);
        idx_clr_en = 1'b1;
        index = 1'b1;
        cyc(12);
        index = 1'b0;
        cyc(12);
        idx_clr_en = 1'b0;
        chk("idx_pos_25", idx_pos, 25);
        chk("idx_valid_set", idx_valid, 1);
        chk("idx_zeroed_pos", position, 0);
        exp_pos = 32'd0;
        fwd_steps(3);
        index = 1'b1;
        cyc(12);
        index = 1'b0;
        cyc(12);
        chk("idx_pos_3", idx_pos, 3);
        chk("idx_no_zero_pos", position, 3);
        fwd_steps(1);
        index = 1'b1;
        cyc(2);
        clr = 1'b1;
        cyc(5);
        clr = 1'b0;
        cyc(5);
        index = 1'b0;
        cyc(12);
        chk("clr_idx_valid", idx_valid, 0);
        chk("clr_idx_pos", idx_pos, 0);
        chk("clr_idx_position", position, 0);
        exp_pos = 32'd0;
        home = 1'b1;
        cyc(15);
        chk("home_rise", home_seen, 1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(15);
        chk("home_level_ignored", home_seen, 0);
        home = 1'b0;
        cyc(12);
        home = 1'b1;
        cyc(15);
        chk("home_rise2", home_seen, 1);
        do fwd_steps(1); while (cur_ab != 2'b11);
        rst_n = 1'b0;
        #1;
        chk("midrst_position", position, 0);
        chk("midrst_dir", dir, 0);
        chk("midrst_step", step, 0);
        chk("midrst_idx_pos", idx_pos, 0);
        chk("midrst_idx_valid", idx_valid, 0);
        chk("midrst_home_seen", home_seen, 0);
        chk("midrst_err", err, 0);
        cyc(3);
        rst_n = 1'b1;
        s0 = step_cnt;
        cyc(30);
        chk("post_rst_no_step", step_cnt - s0, 0);
        chk("post_rst_pos", position, 0);
        chk("post_rst_err", err, 0);
        exp_pos = 32'd0;
        exp_steps = step_cnt;
        fwd_steps(1);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
